// File: rtl/wb_stage_if.sv
// Execute-to-writeback transfer bus: one retiring instruction per accepted handshake.
interface wb_stage_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              ex_valid;
    logic              ex_ready;
    logic              ex_wr_en;
    logic [ADDR_W-1:0] ex_wr_addr;
    logic [1:0]        ex_rf_wr_sel;
    logic [DATA_W-1:0] ex_alu_data;
    logic [DATA_W-1:0] ex_sp_data;
    logic [DATA_W-1:0] ex_in_data;

    modport master (
        output ex_valid, ex_wr_en, ex_wr_addr, ex_rf_wr_sel,
               ex_alu_data, ex_sp_data, ex_in_data,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_wr_en, ex_wr_addr, ex_rf_wr_sel,
               ex_alu_data, ex_sp_data, ex_in_data,
        output ex_ready
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: in-order result buffer feeding the register file write port,
// with late scratch-load fill, decode operand forwarding and hazard stall.
module wb_stage #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_stage_if.slave         ex,
    input  logic              scr_rd_valid,
    input  logic [DATA_W-1:0] scr_rd_data,
    input  logic [ADDR_W-1:0] dec_adrx,
    input  logic [ADDR_W-1:0] dec_adry,
    output logic              fwd_x_hit,
    output logic [DATA_W-1:0] fwd_x_data,
    output logic              fwd_y_hit,
    output logic [DATA_W-1:0] fwd_y_data,
    output logic              hazard_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_din,
    output logic              protocol_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  ok_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              perr_q;

    logic              push, pop;
    logic [DATA_W-1:0] push_data;
    logic              fill_found;
    logic [PTR_W-1:0]  fill_idx;
    logic              x_match, x_ok, y_match, y_ok;
    logic [DATA_W-1:0] x_data, y_data;

    assign ex.ex_ready  = (count_q < CNT_W'(DEPTH));
    assign push         = ex.ex_valid && ex.ex_ready && ex.ex_wr_en;
    assign pop          = rf_we;
    assign protocol_err = perr_q;

    always_comb begin
        case (ex.ex_rf_wr_sel)
            2'd0:    push_data = ex.ex_alu_data;
            2'd2:    push_data = ex.ex_sp_data;
            2'd3:    push_data = ex.ex_in_data;
            default: push_data = '0;
        endcase
    end

    always_comb begin
        rf_we      = valid_q[head_q] && ok_q[head_q];
        rf_wr_addr = rf_we ? addr_q[head_q] : '0;
        rf_din     = rf_we ? data_q[head_q] : '0;
    end

    // Valid entries are contiguous from head, so walking head..head+DEPTH-1
    // visits them oldest first: first pending hit is the fill target, last
    // address hit is the youngest forwarding source.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fill_found = 1'b0;
        fill_idx   = head_q;
        x_match    = 1'b0;
        x_ok       = 1'b0;
        x_data     = '0;
        y_match    = 1'b0;
        y_ok       = 1'b0;
        y_data     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (valid_q[idx]) begin
                if (!fill_found && !ok_q[idx]) begin
                    fill_found = 1'b1;
                    fill_idx   = idx;
                end
                if (addr_q[idx] == dec_adrx) begin
                    x_match = 1'b1;
                    x_ok    = ok_q[idx];
                    x_data  = data_q[idx];
                end
                if (addr_q[idx] == dec_adry) begin
                    y_match = 1'b1;
                    y_ok    = ok_q[idx];
                    y_data  = data_q[idx];
                end
            end
        end
        fwd_x_hit    = x_match && x_ok;
        fwd_x_data   = fwd_x_hit ? x_data : '0;
        fwd_y_hit    = y_match && y_ok;
        fwd_y_data   = fwd_y_hit ? y_data : '0;
        hazard_stall = (x_match && !x_ok) || (y_match && !y_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ok_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            perr_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                ok_q[tail_q]    <= (ex.ex_rf_wr_sel != 2'd1);
                addr_q[tail_q]  <= ex.ex_wr_addr;
                data_q[tail_q]  <= push_data;
                tail_q          <= tail_q + 1'b1;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (scr_rd_valid) begin
                if (fill_found) begin
                    data_q[fill_idx] <= scr_rd_data;
                    ok_q[fill_idx]   <= 1'b1;
                end else begin
                    perr_q <= 1'b1;
                end
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus queues expected register writes,
// a negedge monitor pops and compares them as the DUT retires.
module tb_wb_stage;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              scr_rd_valid = 1'b0;
    logic [DATA_W-1:0] scr_rd_data = '0;
    logic [ADDR_W-1:0] dec_adrx = '0;
    logic [ADDR_W-1:0] dec_adry = '0;
    logic              fwd_x_hit, fwd_y_hit, hazard_stall, rf_we, protocol_err;
    logic [DATA_W-1:0] fwd_x_data, fwd_y_data, rf_din;
    logic [ADDR_W-1:0] rf_wr_addr;

    int errors = 0;
    int checks = 0;
    wr_t sb[$];

    wb_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) exif ();

    wb_stage #(.DEPTH(2), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex           (exif),
        .scr_rd_valid (scr_rd_valid),
        .scr_rd_data  (scr_rd_data),
        .dec_adrx     (dec_adrx),
        .dec_adry     (dec_adry),
        .fwd_x_hit    (fwd_x_hit),
        .fwd_x_data   (fwd_x_data),
        .fwd_y_hit    (fwd_y_hit),
        .fwd_y_data   (fwd_y_data),
        .hazard_stall (hazard_stall),
        .rf_we        (rf_we),
        .rf_wr_addr   (rf_wr_addr),
        .rf_din       (rf_din),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected none", rf_wr_addr, rf_din);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 16'(rf_wr_addr), 16'(e.addr));
                chk("wr_data", 16'(rf_din), 16'(e.data));
            end
        end
    end

    // Drives one transfer; for loads, data is the value the later fill will supply.
    task automatic push(input logic [ADDR_W-1:0] a, input logic [1:0] sel,
                        input logic [DATA_W-1:0] d, input logic wr_en);
        int unsigned waited = 0;
        while (!exif.ex_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!exif.ex_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ex_ready 0 expected 1");
        end
        exif.ex_valid     = 1'b1;
        exif.ex_wr_en     = wr_en;
        exif.ex_wr_addr   = a;
        exif.ex_rf_wr_sel = sel;
        exif.ex_alu_data  = (sel == 2'd0) ? d : ~d;
        exif.ex_sp_data   = (sel == 2'd2) ? d : ~d;
        exif.ex_in_data   = (sel == 2'd3) ? d : ~d;
        if (wr_en) sb.push_back('{addr: a, data: d});
        @(posedge clk); #1;
        exif.ex_valid = 1'b0;
        exif.ex_wr_en = 1'b0;
    endtask

    task automatic fill(input logic [DATA_W-1:0] d);
        scr_rd_valid = 1'b1;
        scr_rd_data  = d;
        @(posedge clk); #1;
        scr_rd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 16'(exif.ex_ready), 16'h1);
        chk({tag, "_we"}, 16'(rf_we), 16'h0);
        chk({tag, "_addr"}, 16'(rf_wr_addr), 16'h0);
        chk({tag, "_din"}, 16'(rf_din), 16'h0);
        chk({tag, "_fwd"}, 16'({fwd_x_hit, fwd_y_hit, fwd_x_data, fwd_y_data}), 16'h0);
        chk({tag, "_stall"}, 16'(hazard_stall), 16'h0);
        chk({tag, "_perr"}, 16'(protocol_err), 16'h0);
    endtask

    initial begin
        exif.ex_valid     = 1'b0;
        exif.ex_wr_en     = 1'b0;
        exif.ex_wr_addr   = '0;
        exif.ex_rf_wr_sel = '0;
        exif.ex_alu_data  = '0;
        exif.ex_sp_data   = '0;
        exif.ex_in_data   = '0;
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU write, forwarded while it sits at the head
        dec_adrx = 5;
        push(5, 2'd0, 8'h3C, 1'b1);
        chk("alu_fwd_hit", 16'(fwd_x_hit), 16'h1);
        chk("alu_fwd_data", 16'(fwd_x_data), 16'h3C);
        @(posedge clk); #1;
        chk("alu_empty_we", 16'(rf_we), 16'h0);
        chk("alu_empty_fwd", 16'(fwd_x_hit), 16'h0);

        // SP and input-port sources, plus a non-writing transfer
        push(9, 2'd2, 8'h5A, 1'b1);
        push(10, 2'd3, 8'hC3, 1'b1);
        push(11, 2'd0, 8'hEE, 1'b0);
        @(posedge clk); #1;
        chk("nowr_we", 16'(rf_we), 16'h0);

        // Load then fill two cycles later
        dec_adrx = 2;
        push(2, 2'd1, 8'hA5, 1'b1);
        chk("load_stall", 16'(hazard_stall), 16'h1);
        chk("load_fwd_hit", 16'(fwd_x_hit), 16'h0);
        chk("load_we", 16'(rf_we), 16'h0);
        @(posedge clk); #1;
        chk("load_we2", 16'(rf_we), 16'h0);
        fill(8'hA5);
        chk("fill_stall", 16'(hazard_stall), 16'h0);
        chk("fill_fwd_hit", 16'(fwd_x_hit), 16'h1);
        chk("fill_fwd_data", 16'(fwd_x_data), 16'hA5);
        @(posedge clk); #1;

        // Full buffer behind a pending load
        dec_adry = 1;
        push(1, 2'd1, 8'h77, 1'b1);
        push(3, 2'd0, 8'h11, 1'b1);
        chk("full_ready", 16'(exif.ex_ready), 16'h0);
        chk("full_stall_y", 16'(hazard_stall), 16'h1);
        fill(8'h77);
        chk("full_ready_fill", 16'(exif.ex_ready), 16'h0);
        @(posedge clk); #1;
        chk("full_ready_pop", 16'(exif.ex_ready), 16'h1);
        @(posedge clk); #1;

        // Youngest r4 wins forwarding even though the older one is pending
        dec_adry = 4;
        dec_adrx = 0;
        push(4, 2'd1, 8'h01, 1'b1);
        push(4, 2'd0, 8'h02, 1'b1);
        chk("prio_hit", 16'(fwd_y_hit), 16'h1);
        chk("prio_data", 16'(fwd_y_data), 16'h02);
        chk("prio_stall", 16'(hazard_stall), 16'h0);
        fill(8'h01);
        repeat (2) @(posedge clk);
        #1;

        // Fill with nothing pending is a sticky protocol error
        fill(8'h99);
        chk("perr_set", 16'(protocol_err), 16'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("perr_sticky", 16'(protocol_err), 16'h1);

        // Reset mid-load discards the pending entry
        dec_adrx = 6;
        push(6, 2'd1, 8'h55, 1'b1);
        chk("mid_stall", 16'(hazard_stall), 16'h1);
        void'(sb.pop_back());
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        fill(8'h55);
        chk("post_rst_perr", 16'(protocol_err), 16'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 16'(sb.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback end of the pipeline. Accepts completed results from the execute stage, buffers them in order, and drives the register file write port (WE / WR_ADR / D_IN).
- Covers the scratch-RAM load case, where data arrives one or more cycles after the instruction retires from execute.
- Provides operand forwarding and a hazard stall to decode, so decode-time register reads (ADRX/ADRY) see the newest value.

Parameters:
- DEPTH, 2, result buffer entries; power of 2, at least 2.
- DATA_W, 8, register data width.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute presents a retiring instruction this cycle.
- ex_ready  out  1  wb_stage can accept; transfer occurs when ex_valid && ex_ready at the rising edge.
- ex_wr_en  in  1  instruction writes the register file (decoder RF_WR).
- ex_wr_addr  in  ADDR_W  destination register.
- ex_rf_wr_sel  in  2  source: 0 ALU, 1 scratch RAM, 2 stack pointer, 3 input port.
- ex_alu_data  in  DATA_W  ALU result.
- ex_sp_data  in  DATA_W  stack pointer value.
- ex_in_data  in  DATA_W  input port value.
- scr_rd_valid  in  1  scratch read data valid this cycle.
- scr_rd_data  in  DATA_W  scratch read data.
- dec_adrx  in  ADDR_W  decode X read address.
- dec_adry  in  ADDR_W  decode Y read address.
- fwd_x_hit  out  1  buffered write to dec_adrx exists and its data is valid.
- fwd_x_data  out  DATA_W  forwarded X value.
- fwd_y_hit  out  1  same, for Y.
- fwd_y_data  out  DATA_W  forwarded Y value.
- hazard_stall  out  1  decode must stall: the newest matching entry for X or Y has pending scratch data.
- rf_we  out  1  register file write enable.
- rf_wr_addr  out  ADDR_W  register file write address.
- rf_din  out  DATA_W  register file write data.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0):
  - Buffer empty; all entries invalid.
  - ex_ready=1, rf_we=0, rf_wr_addr=0, rf_din=0.
  - fwd_*_hit=0, fwd_*_data=0, hazard_stall=0, protocol_err=0.
  - Reset mid-operation discards all entries, including pending loads.
- Buffer: circular FIFO with head/tail pointers and count (0..DEPTH).
  - Entry fields: valid, addr, data, data_ok.
  - ex_ready = (count < DEPTH). No same-cycle push-when-full bypass.
- Push (ex_valid && ex_ready && ex_wr_en):
  - Store the addr.
  - sel 0/2/3: store the selected data, data_ok=1.
  - sel 1: data_ok=0 (load pending).
  - A transfer with ex_wr_en=0 is consumed and not stored.
- Scratch fill:
  - scr_rd_valid writes scr_rd_data into the oldest entry with data_ok=0 and sets data_ok.
  - Loads complete in order.
  - scr_rd_valid with no pending entry: data ignored, protocol_err set until reset.
- Retire (combinational from head):
  - rf_we = head.valid && head.data_ok; rf_wr_addr=head.addr; rf_din=head.data.
  - Head pops at the rising edge where rf_we=1. At most one write per cycle.
  - When rf_we=0, rf_wr_addr and rf_din are held at 0.
- Latency (non-load, empty buffer): accepted at edge N; rf_we high during cycle N..N+1; register file written at edge N+1.
- Head pending: no retire. Younger entries wait behind it (in-order).
- Simultaneous push and pop in one cycle: count unchanged; legal at any count < DEPTH.
- Simultaneous scr_rd_valid fill of the head and retire in the same cycle: not allowed. The fill takes effect at the edge; retire happens next cycle.
- Forwarding (combinational):
  - For each of X and Y, search all valid entries for a matching addr; the youngest match wins.
  - Winner data_ok=1: hit=1, data=entry data.
  - Winner data_ok=0: hit=0 and hazard_stall=1.
  - No match: hit=0, data=0.
  - The head entry being retired this cycle still forwards. The register file updates only at the edge.
- No register is special; address 0 is treated like any other.

Test Plan:
- ALU write: push addr 5, sel 0, alu 0x3C into an empty buffer -> next cycle rf_we=1, rf_wr_addr=5, rf_din=0x3C; buffer empty after that edge.
- Load then fill: push addr 2, sel 1; scr_rd_valid with 0xA5 two cycles later -> rf_we stays 0 until the cycle after the fill, then writes addr 2 = 0xA5. While the entry is pending, dec_adrx=2 gives hazard_stall=1.
- Full/backpressure: push load r1 then ALU r3=0x11 -> ex_ready=0. Fill r1=0x77 -> writes r1=0x77 then r3=0x11 on consecutive cycles; ex_ready returns to 1 after the first pop.
- Forwarding priority: buffer holds r4=0x01 (older) and r4=0x02 (younger) with dec_adry=4 -> fwd_y_hit=1, fwd_y_data=0x02. Retires occur in order 0x01, then 0x02.
- Errors and reset: scr_rd_valid with an empty buffer -> protocol_err=1 and stays set. Assert rst_n=0 mid-load -> all outputs return to reset values immediately and protocol_err clears.
